word_display_reader: RTL and testbench

//  Read side of the hangman word store. On a start pulse, scans word RAM addresses 1..length
//  (the writer stores chars from address 1), merges each char with a per-position reveal mask,
//  and streams one display symbol per position: the letter if revealed, else the dash code.

---
 rtl/hangman_pkg.sv | 21 ++
 rtl/rd_lat_pipe.sv | 35 +++
 rtl/word_display_reader.sv | 141 ++++++++++++++
 tb/tb_word_display_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared hangman definitions: char encoding, display constants and the
// word-store FSM state type used by both the writer and the display reader.
package hangman_pkg;

    localparam int HM_CHAR_W = 5;
    localparam int HM_ADDR_W = 5;

    localparam logic [HM_CHAR_W-1:0] HM_CH_EMPTY  = 5'd0;
    localparam logic [HM_CHAR_W-1:0] HM_CH_A      = 5'd1;
    localparam logic [HM_CHAR_W-1:0] HM_CH_Z      = 5'd26;
    localparam logic [HM_CHAR_W-1:0] HM_DASH_CODE = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } word_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid/bit shift register DEPTH stages deep; keeps a reveal bit aligned
// with the RAM read data that returns DEPTH cycles after rden.
module rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic in_vld,
    input  logic in_bit,
    output logic out_vld,
    output logic out_bit
);

    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] bit_r;

    // shift the valid flag and its reveal bit one stage per cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_r <= '0;
            bit_r <= '0;
        end else begin
            vld_r[0] <= in_vld;
            bit_r[0] <= in_bit;
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                bit_r[i] <= bit_r[i-1];
            end
        end
    end

    assign out_vld = vld_r[DEPTH-1];
    assign out_bit = bit_r[DEPTH-1];

endmodule

// File: rtl/word_display_reader.sv
// Read side of the hangman word store: scans RAM positions 1..length and streams
// letter-or-dash symbols. Optional macro WORD_DISPLAY_WIN_EN adds all_revealed.
module word_display_reader
    import hangman_pkg::*;
#(
    parameter int                  CHAR_W    = HM_CHAR_W,
    parameter int                  ADDR_W    = HM_ADDR_W,
    parameter int                  RD_LAT    = 1,
    parameter logic [CHAR_W-1:0]   DASH_CODE = HM_DASH_CODE
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      length,
    input  logic [2**ADDR_W-1:0]   reveal_mask,
    output logic [ADDR_W-1:0]      rd_addr,
    output logic                   rden,
    input  logic [CHAR_W-1:0]      rd_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHAR_W-1:0]      out_char,
    output logic [ADDR_W-1:0]      out_pos,
    output logic                   out_blank,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
`ifdef WORD_DISPLAY_WIN_EN
    ,
    output logic                   all_revealed
`endif
);

    word_state_e       state_r;
    logic [ADDR_W-1:0] pos_r;
    logic [ADDR_W-1:0] len_r;
    logic              pipe_vld_s;
    logic              pipe_bit_s;
`ifdef WORD_DISPLAY_WIN_EN
    logic              acc_r;
`endif

    // reveal bit is sampled while rden is high, i.e. in the ISSUE cycle
    rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_pipe (
        .clk     (clk),
        .resetn  (resetn),
        .in_vld  (rden),
        .in_bit  (reveal_mask[rd_addr]),
        .out_vld (pipe_vld_s),
        .out_bit (pipe_bit_s)
    );

    // scan FSM with all outputs registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            pos_r     <= '0;
            len_r     <= '0;
            rd_addr   <= '0;
            rden      <= 1'b0;
            out_valid <= 1'b0;
            out_char  <= '0;
            out_pos   <= '0;
            out_blank <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef WORD_DISPLAY_WIN_EN
            acc_r        <= 1'b0;
            all_revealed <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_r <= length;
`ifdef WORD_DISPLAY_WIN_EN
                        acc_r        <= (length != '0);
                        all_revealed <= 1'b0;
`endif
                        if (length != '0) begin
                            pos_r   <= ADDR_W'(1);
                            rd_addr <= ADDR_W'(1);
                            rden    <= 1'b1;
                            busy    <= 1'b1;
                            state_r <= ST_ISSUE;
                        end else begin
                            done    <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    rden    <= 1'b0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pipe_vld_s) begin
                        out_valid <= 1'b1;
                        out_char  <= pipe_bit_s ? rd_q : DASH_CODE;
                        out_blank <= ~pipe_bit_s;
                        out_pos   <= pos_r;
                        out_last  <= (pos_r == len_r);
`ifdef WORD_DISPLAY_WIN_EN
                        acc_r     <= acc_r & pipe_bit_s;
`endif
                        state_r   <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (pos_r == len_r) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
`ifdef WORD_DISPLAY_WIN_EN
                            all_revealed <= acc_r;
`endif
                            state_r <= ST_DONE;
                        end else begin
                            pos_r   <= pos_r + ADDR_W'(1);
                            rd_addr <= pos_r + ADDR_W'(1);
                            rden    <= 1'b1;
                            state_r <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_display_reader.sv
// Scoreboard bench for word_display_reader: directed scans against a model RAM,
// expected symbols queued by the stimulus and checked by a negedge monitor.
module tb_word_display_reader;

    typedef struct packed {
        logic [4:0] pos;
        logic [4:0] ch;
        logic       blank;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  length = 5'd0;
    logic [31:0] reveal_mask = 32'd0;
    logic [4:0]  rd_addr;
    logic        rden;
    logic [4:0]  rd_q = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_char;
    logic [4:0]  out_pos;
    logic        out_blank;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef WORD_DISPLAY_WIN_EN
    logic        all_revealed;
`endif

    logic [4:0] mem [0:31];
    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         rden_cnt = 0;
    int         done_cnt = 0;

    word_display_reader dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .length      (length),
        .reveal_mask (reveal_mask),
        .rd_addr     (rd_addr),
        .rden        (rden),
        .rd_q        (rd_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_char    (out_char),
        .out_pos     (out_pos),
        .out_blank   (out_blank),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
`ifdef WORD_DISPLAY_WIN_EN
        ,
        .all_revealed(all_revealed)
`endif
    );

    always #5 clk = ~clk;

    // one-cycle-latency word RAM read port
    always @(posedge clk) begin
        if (rden) rd_q <= mem[rd_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // monitor: count pulses and score every accepted symbol
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (rden) rden_cnt++;
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            a = '{pos: out_pos, ch: out_char, blank: out_blank, last: out_last};
            if (exp_q.size() == 0) begin
                check("sb_unexpected_symbol", int'(a), -1);
            end else begin
                e = exp_q.pop_front();
                check("sb_symbol", int'(a), int'(e));
            end
        end
    end

    task automatic push(input logic [4:0] p, input logic [4:0] c, input logic b, input logic l);
        exp_q.push_back('{pos: p, ch: c, blank: b, last: l});
    endtask

    task automatic pulse_start(input logic [4:0] len);
        start = 1'b1;
        length = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("valid_seen", int'(out_valid), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_rden"},      int'(rden), 0);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_done"},      int'(done), 0);
        check({tag, "_out_char"},  int'(out_char), 0);
        check({tag, "_out_pos"},   int'(out_pos), 0);
        check({tag, "_out_blank"}, int'(out_blank), 0);
        check({tag, "_out_last"},  int'(out_last), 0);
        check({tag, "_rd_addr"},   int'(rd_addr), 0);
    endtask

    initial begin
        int r0;
        int d0;
        logic [4:0] hold_ch;
        logic [4:0] hold_pos;
        for (int i = 0; i < 32; i++) mem[i] = 5'd0;
        mem[1] = 5'd3;   // C
        mem[2] = 5'd1;   // A
        mem[3] = 5'd20;  // T

        #12;
        check_idle_outputs("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // CAT with only position 2 revealed, renderer always ready
        reveal_mask = 32'b0100;
        push(5'd1, 5'd31, 1'b1, 1'b0);
        push(5'd2, 5'd1,  1'b0, 1'b0);
        push(5'd3, 5'd31, 1'b1, 1'b1);
        r0 = rden_cnt; d0 = done_cnt;
        pulse_start(5'd3);
        check("t1_rden_after_start", int'(rden), 1);
        check("t1_rd_addr_first", int'(rd_addr), 1);
        check("t1_busy", int'(busy), 1);
        check("t1_valid_early0", int'(out_valid), 0);
        @(posedge clk); #1;
        check("t1_valid_early1", int'(out_valid), 0);
        @(posedge clk); #1;
        check("t1_first_valid_latency", int'(out_valid), 1);
        wait_done(40);
        check("t1_done_one_cycle", int'(done), 0);
        check("t1_busy_after_done", int'(busy), 0);
        check("t1_rden_count", rden_cnt - r0, 3);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_sb_drained", exp_q.size(), 0);

        // mask 0b1010 reveals positions 1 and 3
        reveal_mask = 32'b1010;
        push(5'd1, 5'd3,  1'b0, 1'b0);
        push(5'd2, 5'd31, 1'b1, 1'b0);
        push(5'd3, 5'd20, 1'b0, 1'b1);
        pulse_start(5'd3);
        wait_done(40);
        check("t1b_sb_drained", exp_q.size(), 0);

        // backpressure held 4 cycles on position 2
        reveal_mask = 32'b0100;
        out_ready = 1'b0;
        push(5'd1, 5'd31, 1'b1, 1'b0);
        push(5'd2, 5'd1,  1'b0, 1'b0);
        push(5'd3, 5'd31, 1'b1, 1'b1);
        r0 = rden_cnt;
        pulse_start(5'd3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(20);
            if (out_pos == 5'd2) begin
                hold_ch = out_char;
                hold_pos = out_pos;
                repeat (4) @(posedge clk);
                #1;
                check("t2_char_stable", int'(out_char), int'(hold_ch));
                check("t2_pos_stable", int'(out_pos), 2);
                check("t2_valid_held", int'(out_valid), 1);
                check("t2_no_rden_while_pending", rden_cnt - r0, 2);
                check("t2_hold_pos", int'(hold_pos), 2);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        wait_done(20);
        out_ready = 1'b1;
        check("t2_rden_count", rden_cnt - r0, 3);
        check("t2_sb_drained", exp_q.size(), 0);

        // zero length: immediate done, no reads, no symbols
        r0 = rden_cnt; d0 = done_cnt;
        pulse_start(5'd0);
        check("t3_done_pulse", int'(done), 1);
        check("t3_busy_low", int'(busy), 0);
        @(posedge clk); #1;
        check("t3_done_cleared", int'(done), 0);
        check("t3_no_rden", rden_cnt - r0, 0);
        check("t3_done_count", done_cnt - d0, 1);
        check("t3_no_valid", int'(out_valid), 0);
`ifdef WORD_DISPLAY_WIN_EN
        check("t3_all_revealed_len0", int'(all_revealed), 0);
`endif

        // second start mid-scan is ignored
        push(5'd1, 5'd31, 1'b1, 1'b0);
        push(5'd2, 5'd1,  1'b0, 1'b0);
        push(5'd3, 5'd31, 1'b1, 1'b1);
        r0 = rden_cnt; d0 = done_cnt;
        pulse_start(5'd3);
        @(posedge clk); #1;
        pulse_start(5'd5);
        wait_done(40);
        repeat (6) @(posedge clk);
        #1;
        check("t4_rden_count", rden_cnt - r0, 3);
        check("t4_done_count", done_cnt - d0, 1);
        check("t4_idle_after", int'(busy), 0);
        check("t4_sb_drained", exp_q.size(), 0);

        // asynchronous reset while a symbol is presented
        out_ready = 1'b0;
        push(5'd1, 5'd31, 1'b1, 1'b0);
        pulse_start(5'd3);
        wait_valid(20);
        #2;
        resetn = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        out_ready = 1'b1;
        reveal_mask = 32'b0110;
        push(5'd1, 5'd3, 1'b0, 1'b0);
        push(5'd2, 5'd1, 1'b0, 1'b1);
        @(posedge clk); #1;
        d0 = done_cnt;
        pulse_start(5'd2);
        check("t5_restart_addr", int'(rd_addr), 1);
        wait_done(40);
        check("t5_done_count", done_cnt - d0, 1);
        check("t5_sb_drained", exp_q.size(), 0);

        // empty slot on revealed position passes through as 0
        mem[1] = 5'd26;
        mem[2] = 5'd0;
        reveal_mask = 32'b0110;
        push(5'd1, 5'd26, 1'b0, 1'b0);
        push(5'd2, 5'd0,  1'b0, 1'b1);
        pulse_start(5'd2);
        wait_done(40);
`ifdef WORD_DISPLAY_WIN_EN
        check("t6_all_revealed_set", int'(all_revealed), 1);
`endif
        reveal_mask = 32'b0010;
        push(5'd1, 5'd26, 1'b0, 1'b0);
        push(5'd2, 5'd31, 1'b1, 1'b1);
        pulse_start(5'd2);
        wait_done(40);
`ifdef WORD_DISPLAY_WIN_EN
        check("t6_all_revealed_clear", int'(all_revealed), 0);
`endif
        check("t6_sb_drained", exp_q.size(), 0);

        // maximum length, odd positions revealed, last at 31
        for (int p = 1; p < 32; p++) begin
            mem[p] = 5'(p);
            push(5'(p), (p % 2 == 1) ? 5'(p) : 5'd31, (p % 2 == 0), (p == 31));
        end
        reveal_mask = 32'hAAAA_AAAA;
        r0 = rden_cnt;
        pulse_start(5'd31);
        wait_done(200);
        check("t7_rden_count", rden_cnt - r0, 31);
        check("t7_sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
